router_register_param: RTL and testbench



---
 rtl/router_register_param.sv | 133 +++++++++++++
 tb/tb_router_register_param.sv | 136 +++++++++++++
 2 files changed

// File: rtl/router_register_param.sv
// router_register_param
// Packet register between the router input stage and the FSM/FIFO write path.
// It captures the header word, holds one word while the target FIFO is full,
// and forwards header, payload and check words on dout. It accumulates a
// running check value (XOR or wrapping sum), compares it with the source check
// word, and compares the header length field with the number of payload words.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   pkt_valid          source word valid / packet in progress
//   fifo_full          selected FIFO is full
//   rst_int_reg        FSM end-of-packet, clears low_pkt_valid
//   detect_add, lfd_state, ld_state, laf_state, full_state
//                      FSM state decodes, at most one high
//   data_in            source word
//   dout               word to FIFO
//   hdr_addr           captured header address
//   parity_done        source check word has been consumed
//   low_pkt_valid      pkt_valid fell while loading
//   err                check value mismatch
//   len_err            payload count differs from header length
module router_register_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_CH     = 3,
    parameter int CHECK_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  pkt_valid,
    input  logic                  fifo_full,
    input  logic                  rst_int_reg,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [ADDR_WIDTH-1:0] hdr_addr,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err,
    output logic                  len_err
);

    localparam int LEN_W = DATA_WIDTH - ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] header_reg;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [DATA_WIDTH-1:0] int_chk;
    logic [DATA_WIDTH-1:0] pkt_chk;
    logic [LEN_W-1:0]      pay_cnt;

    logic hdr_ok;
    logic hdr_take;
    logic chk_direct;
    logic chk_held;

    // Headers addressing a non-existent channel are dropped without side effects.
    assign hdr_ok     = (int'(data_in[ADDR_WIDTH-1:0]) < NUM_CH);
    assign hdr_take   = detect_add && pkt_valid && hdr_ok;
    // Check word arrives on the cycle pkt_valid drops; if the FIFO is full it
    // was parked in hold_reg and is picked up again during laf_state.
    assign chk_direct = ld_state && !pkt_valid && !fifo_full;
    assign chk_held   = laf_state && low_pkt_valid && !parity_done;

    function automatic logic [DATA_WIDTH-1:0] chk_op(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        if (CHECK_MODE == 1) return a + b;
        else                 return a ^ b;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            header_reg    <= '0;
            hold_reg      <= '0;
            int_chk       <= '0;
            pkt_chk       <= '0;
            pay_cnt       <= '0;
            dout          <= '0;
            hdr_addr      <= '0;
            parity_done   <= 1'b0;
            low_pkt_valid <= 1'b0;
            err           <= 1'b0;
            len_err       <= 1'b0;
        end else begin
            // header capture and running check value
            if (hdr_take) begin
                header_reg <= data_in;
                hdr_addr   <= data_in[ADDR_WIDTH-1:0];
                int_chk    <= '0;
                pay_cnt    <= '0;
            end else if (lfd_state) begin
                int_chk <= chk_op(int_chk, header_reg);
            end else if (ld_state && pkt_valid && !full_state) begin
                int_chk <= chk_op(int_chk, data_in);
                pay_cnt <= pay_cnt + LEN_W'(1);
            end

            // forward path to the FIFO
            if (lfd_state)                   dout <= header_reg;
            else if (ld_state && !fifo_full) dout <= data_in;
            else if (laf_state)              dout <= hold_reg;

            if (ld_state && fifo_full) hold_reg <= data_in;

            // set has priority over the FSM clear
            if (ld_state && !pkt_valid) low_pkt_valid <= 1'b1;
            else if (rst_int_reg)       low_pkt_valid <= 1'b0;

            // a new valid header wipes the previous packet's status
            if (hdr_take) begin
                parity_done <= 1'b0;
                err         <= 1'b0;
                len_err     <= 1'b0;
            end else begin
                if (chk_direct) begin
                    pkt_chk     <= data_in;
                    parity_done <= 1'b1;
                end else if (chk_held) begin
                    pkt_chk     <= hold_reg;
                    parity_done <= 1'b1;
                end
                if (parity_done) begin
                    err <= (int_chk != pkt_chk);
                    if (pay_cnt != header_reg[DATA_WIDTH-1:ADDR_WIDTH]) len_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_register_param.sv
module tb_router_register_param;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       pkt_valid = 1'b0, fifo_full = 1'b0, rst_int_reg = 1'b0;
    logic       detect_add = 1'b0, lfd_state = 1'b0, ld_state = 1'b0;
    logic       laf_state = 1'b0, full_state = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] dout0, dout1;
    logic [1:0] hdr_addr0, hdr_addr1;
    logic       parity_done0, parity_done1, low_pkt_valid0, low_pkt_valid1;
    logic       err0, err1, len_err0, len_err1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    router_register_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_CH(3), .CHECK_MODE(0)) dut0 (
        .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
        .rst_int_reg(rst_int_reg), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .data_in(data_in), .dout(dout0), .hdr_addr(hdr_addr0), .parity_done(parity_done0),
        .low_pkt_valid(low_pkt_valid0), .err(err0), .len_err(len_err0)
    );

    router_register_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_CH(3), .CHECK_MODE(1)) dut1 (
        .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
        .rst_int_reg(rst_int_reg), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .data_in(data_in), .dout(dout1), .hdr_addr(hdr_addr1), .parity_done(parity_done1),
        .low_pkt_valid(low_pkt_valid1), .err(err1), .len_err(len_err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pkt_valid = 0; fifo_full = 0; rst_int_reg = 0; detect_add = 0;
        lfd_state = 0; ld_state = 0; laf_state = 0; full_state = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full packet; e0/e1 are the expected err of the XOR / sum instance.
    task automatic run_pkt(input logic [7:0] hdr, input logic [7:0] base, input int n,
                           input logic [7:0] cw, input bit full_chk,
                           input bit e0, input bit e1, input bit le);
        logic [7:0] w;
        idle(); detect_add = 1; pkt_valid = 1; data_in = hdr; step();
        chk("hdr_addr", 32'(hdr_addr0), 32'(hdr[1:0]));
        chk("pd_clear", 32'(parity_done0), 0);
        chk("err0_clear", 32'(err0), 0);
        chk("err1_clear", 32'(err1), 0);
        chk("len_clear", 32'(len_err0), 0);
        idle(); lfd_state = 1; pkt_valid = 1; data_in = base; step();
        chk("dout_hdr", 32'(dout0), 32'(hdr));
        for (int i = 0; i < n; i++) begin
            w = base + 8'(i);
            idle(); ld_state = 1; pkt_valid = 1; data_in = w; step();
            chk("dout_pay0", 32'(dout0), 32'(w));
            chk("dout_pay1", 32'(dout1), 32'(w));
        end
        idle(); ld_state = 1; pkt_valid = 0; fifo_full = full_chk; data_in = cw; step();
        chk("low_pkt_valid", 32'(low_pkt_valid0), 1);
        if (full_chk) begin
            chk("dout_held", 32'(dout0), 32'(w));
            chk("pd_wait", 32'(parity_done0), 0);
            idle(); laf_state = 1; step();
            chk("dout_laf", 32'(dout0), 32'(cw));
        end else begin
            chk("dout_chk", 32'(dout0), 32'(cw));
        end
        chk("pd_set", 32'(parity_done0), 1);
        idle(); rst_int_reg = 1; step();
        chk("err0", 32'(err0), 32'(e0));
        chk("err1", 32'(err1), 32'(e1));
        chk("len_err0", 32'(len_err0), 32'(le));
        chk("len_err1", 32'(len_err1), 32'(le));
        chk("lpv_clear", 32'(low_pkt_valid0), 0);
        chk("pd_hold", 32'(parity_done0), 1);
    endtask

    initial begin
        #3;
        chk("rst_dout", 32'(dout0), 0);
        chk("rst_hdr", 32'(hdr_addr0), 0);
        chk("rst_flags", {28'd0, parity_done0, low_pkt_valid0, err0, len_err0}, 0);
        #10 rstn = 1;

        // XOR 0x12 / sum 0x20
        run_pkt(8'h16, 8'h00, 5, 8'h12, 0, 0, 1, 0);
        run_pkt(8'h16, 8'h00, 5, 8'h13, 0, 1, 1, 0);
        run_pkt(8'h16, 8'h00, 5, 8'h20, 0, 1, 0, 0);
        // short packet: XOR 0x16, sum 0x1C
        run_pkt(8'h16, 8'h00, 4, 8'h16, 0, 0, 1, 1);
        // check word blocked by full FIFO
        run_pkt(8'h16, 8'h00, 5, 8'h12, 1, 0, 1, 0);

        // invalid address: nothing captured, flags untouched
        idle(); detect_add = 1; pkt_valid = 1; data_in = 8'h07; step();
        chk("bad_hdr_addr", 32'(hdr_addr0), 2);
        chk("bad_hdr_pd", 32'(parity_done0), 1);
        chk("bad_hdr_err1", 32'(err1), 1);

        // reset mid-payload
        idle(); detect_add = 1; pkt_valid = 1; data_in = 8'h16; step();
        idle(); lfd_state = 1; pkt_valid = 1; data_in = 8'h07; step();
        idle(); ld_state = 1; pkt_valid = 1; data_in = 8'h07; step();
        data_in = 8'h08; step();
        chk("pre_rst_dout", 32'(dout0), 8);
        #2 rstn = 0;
        #1;
        chk("async_dout", 32'(dout0), 0);
        chk("async_dout1", 32'(dout1), 0);
        chk("async_hdr", 32'(hdr_addr0), 0);
        chk("async_flags", {28'd0, parity_done0, low_pkt_valid0, err0, len_err0}, 0);
        idle(); step();
        rstn = 1;
        // XOR 0x1D / sum 0x2B, length 4
        run_pkt(8'h11, 8'h05, 4, 8'h1D, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
